conv_ctrl: RTL
==============

CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 SHALL have parameter K, default 5, kernel edge length.
REQ-002 SHALL have parameter N_KER0, default 6, kernels in layer 0.
REQ-003 SHALL have parameter N_KER1, default 12, kernels in layer 1.
REQ-004 SHALL have parameter WADDR_W, default 10, weight-memory address width.
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port go  in  1  one-cycle layer-start request.
REQ-008 SHALL have port layer  in  1  layer select; 0: 28x28 input, 1: 12x12 input.
REQ-009 SHALL have port conv_ovalid  in  1  output-valid from the convolution engine.
REQ-010 SHALL have port wt_rd  out  1  weight-memory read strobe.
REQ-011 SHALL have port wt_addr  out  WADDR_W  weight-memory bit address.
REQ-012 SHALL have port conv_weight_en  out  1  weight-valid to the engine.
REQ-013 SHALL have port conv_start  out  1  engine run/enable.
REQ-014 SHALL have port conv_state  out  1  layer select to the engine.
REQ-015 SHALL have port win_start  out  1  sliding-window start.
REQ-016 SHALL have port out_we  out  1  result-buffer write enable.
REQ-017 SHALL have port out_addr  out  14  result-buffer address.
REQ-018 SHALL have port kernel_idx  out  4  current kernel index.
REQ-019 SHALL have ports busy and done  out  1 each  busy level and one-cycle completion pulse.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, RUN, GAP, FIN.
REQ-021 IDLE: go=1 SHALL latch layer into conv_state, clear kernel_idx, and enter LOAD next cycle; go SHALL be ignored in all other states.
REQ-022 LOAD SHALL last 26 cycles (load counter i = 0..25).
- wt_rd=1 for i=0..24.
- wt_addr = base + kernel_idx*K*K + i.
- base = 0 for layer 0; base = N_KER0*K*K (150) for layer 1.
REQ-023 conv_weight_en SHALL be wt_rd delayed one cycle, matching one-cycle memory read latency.
REQ-024 conv_start SHALL be 1 in LOAD and RUN, and 0 in IDLE, GAP and FIN.
REQ-025 LOAD SHALL exit to RUN after i=25; win_start SHALL be 1 throughout RUN.
REQ-026 RUN SHALL count conv_ovalid cycles in out_cnt; OUT_N = (28-K+1)^2 = 576 for layer 0 and (12-K+1)^2 = 64 for layer 1.
REQ-027 RUN: out_we SHALL equal conv_ovalid combinationally; out_addr SHALL equal kernel_idx*OUT_N + out_cnt (pre-increment value).
REQ-028 RUN: the cycle in which the OUT_N-th conv_ovalid arrives SHALL move the FSM to GAP; later conv_ovalid SHALL be ignored, with out_we=0.
REQ-029 GAP SHALL last exactly 2 cycles with conv_start=0 and win_start=0, then:
- if kernel_idx == NK-1 (NK = N_KER0 or N_KER1 per latched layer), go to FIN;
- otherwise increment kernel_idx, clear out_cnt, and go to LOAD.
REQ-030 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-031 busy SHALL be 1 in LOAD, RUN, GAP and FIN, and 0 in IDLE.
REQ-032 A change on layer while busy SHALL have no effect until the next accepted go.
REQ-033 out_cnt SHALL be 10 bits wide; out_addr arithmetic SHALL not overflow (max 6*576-1 = 3455).

Reset
REQ-034 rst=1 SHALL, at the next clock edge, force IDLE from any state, including mid-LOAD or mid-RUN.
REQ-035 rst SHALL clear all outputs, kernel_idx, out_cnt and the load counter to 0; a go coincident with rst SHALL be ignored.

Verification
REQ-036 layer=0, go pulse; memory model returns addr[0]:
- wt_rd asserted 25 cycles with addresses 0..24;
- conv_weight_en high for the 25 cycles one cycle later;
- conv_start high through LOAD and RUN.
REQ-037 layer=0, engine model emits 576 ovalid pulses per kernel:
- out_addr covers 0..3455 contiguously;
- conv_start low exactly 2 cycles between kernels;
- kernel_idx runs 0..5;
- a single done pulse, then busy=0.
REQ-038 layer=1: first wt_addr = 150; OUT_N = 64; 12 kernels; last out_addr = 767; done pulses once.
REQ-039 Engine emits 600 ovalid pulses for kernel 0 → exactly 576 out_we pulses; pulses 577..600 produce no writes.
REQ-040 rst asserted at RUN out_cnt=100 → next cycle all outputs 0 and busy=0; a following go restarts at wt_addr=0.
REQ-041 go pulsed while busy, and layer toggled mid-run → no restart, conv_state unchanged, completion identical to an undisturbed run.

Source files
------------

// File: rtl/conv_ctrl.sv
// Conv layer sequencer: per kernel, load K*K weights, run until OUT_N results are written, idle 2 cycles.
// Weight-enable lags the read strobe by one cycle; no backpressure, excess conv_ovalid is dropped.
module conv_ctrl #(
  parameter int K       = 5,
  parameter int N_KER0  = 6,
  parameter int N_KER1  = 12,
  parameter int WADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               layer,
  input  logic               conv_ovalid,
  output logic               wt_rd,
  output logic [WADDR_W-1:0] wt_addr,
  output logic               conv_weight_en,
  output logic               conv_start,
  output logic               conv_state,
  output logic               win_start,
  output logic               out_we,
  output logic [13:0]        out_addr,
  output logic [3:0]         kernel_idx,
  output logic               busy,
  output logic               done
);

  localparam int KK     = K * K;
  localparam int LD_W   = $clog2(KK + 1);
  localparam int OUT_N0 = (28 - K + 1) * (28 - K + 1);
  localparam int OUT_N1 = (12 - K + 1) * (12 - K + 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, FIN} state_t;

  state_t            state, state_nxt;
  logic [LD_W-1:0]   ld_cnt;
  logic [9:0]        out_cnt;
  logic              gap_cnt;
  logic [9:0]        out_n;
  logic              last_k;
  logic [WADDR_W-1:0] wt_base;

  // Layer-dependent constants follow the layer latched at go, never the live input.
  assign out_n   = conv_state ? 10'(OUT_N1) : 10'(OUT_N0);
  assign last_k  = conv_state ? (kernel_idx == 4'(N_KER1 - 1)) : (kernel_idx == 4'(N_KER0 - 1));
  assign wt_base = conv_state ? WADDR_W'(N_KER0 * KK) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ld_cnt         <= '0;
      out_cnt        <= '0;
      gap_cnt        <= 1'b0;
      kernel_idx     <= '0;
      conv_state     <= 1'b0;
      conv_weight_en <= 1'b0;
    end else begin
      state          <= state_nxt;
      conv_weight_en <= wt_rd;
      case (state)
        IDLE: begin
          if (go) begin
            conv_state <= layer;
            kernel_idx <= '0;
            out_cnt    <= '0;
            ld_cnt     <= '0;
          end
        end
        LOAD: begin
          if (ld_cnt == LD_W'(KK)) ld_cnt <= '0;
          else                     ld_cnt <= ld_cnt + 1'b1;
        end
        RUN: begin
          if (conv_ovalid) out_cnt <= out_cnt + 10'd1;
        end
        GAP: begin
          gap_cnt <= ~gap_cnt;
          if (gap_cnt && !last_k) begin
            kernel_idx <= kernel_idx + 4'd1;
            out_cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    wt_rd      = 1'b0;
    wt_addr    = '0;
    conv_start = 1'b0;
    win_start  = 1'b0;
    out_we     = 1'b0;
    out_addr   = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (go) state_nxt = LOAD;
      end
      LOAD: begin
        conv_start = 1'b1;
        wt_rd      = (ld_cnt < LD_W'(KK));
        wt_addr    = wt_base + WADDR_W'(kernel_idx) * WADDR_W'(KK) + WADDR_W'(ld_cnt);
        if (ld_cnt == LD_W'(KK)) state_nxt = RUN;
      end
      RUN: begin
        conv_start = 1'b1;
        win_start  = 1'b1;
        out_we     = conv_ovalid;
        out_addr   = 14'(kernel_idx) * 14'(out_n) + 14'(out_cnt);
        if (conv_ovalid && (out_cnt == out_n - 10'd1)) state_nxt = GAP;
      end
      GAP: begin
        if (gap_cnt) state_nxt = last_k ? FIN : LOAD;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
